ahb_slave_arbiter: RTL and testbench

- Per-slave-port AHB arbiter that shares one slave between up to MASTER_NUM requesting masters.
- Produces the one-hot address-phase select and the one-hot data-phase select that drive the slave-side payload muxes.
- Uses round-robin priority, holds ownership through bursts and locked sequences, and changes ownership only on HREADY-qualified boundaries.
- Sits between the per-master address decoders (request sources) and the slave's request/response muxes.

---
 rtl/ahb_slave_arbiter.sv | 151 +++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - round-robin AHB slave-port arbiter with burst/lock hold
// Grants one master the slave's address phase and tracks the data-phase owner one hready edge later.
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          i_hclk,
  input  logic                          i_hreset,
  input  logic [MASTER_NUM-1:0]         i_hreq,
  input  logic [MASTER_NUM-1:0]         i_hlock,
  input  logic [MASTER_NUM-1:0][1:0]    i_htrans,
  input  logic                          i_hready,
  output logic [MASTER_NUM-1:0]         o_addr_sel,
  output logic [MASTER_NUM-1:0]         o_data_sel,
  output logic [$clog2(MASTER_NUM)-1:0] o_hmaster,
  output logic                          o_busy
);

  localparam int IW = $clog2(MASTER_NUM);
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_owner, w_owner_nxt;
  logic [IW-1:0]         r_last, w_last_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [MASTER_NUM-1:0] r_addr_sel, w_addr_sel_nxt;
  logic [MASTER_NUM-1:0] r_data_sel, w_data_sel_nxt;
  logic [IW-1:0]         r_hmaster, w_hmaster_nxt;
  logic                  r_busy, w_busy_nxt;

  logic [1:0]            w_own_trans;
  logic                  w_own_active;
  logic                  w_own_req;
  logic                  w_own_lock;
  logic [MASTER_NUM-1:0] w_req_others;
  logic [IW-1:0]         w_cand_all;
  logic [IW-1:0]         w_cand_others;

  // First requester scanning cyclically from last+1; last itself is visited last.
  function automatic logic [IW-1:0] f_pick(input logic [MASTER_NUM-1:0] req,
                                           input logic [IW-1:0] last);
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      idx = IW'((int'(last) + i) % MASTER_NUM);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_own_trans   = i_htrans[r_owner];
  assign w_own_active  = (w_own_trans == 2'b10) || (w_own_trans == 2'b11);
  assign w_own_req     = i_hreq[r_owner];
  assign w_own_lock    = i_hlock[r_owner];
  // r_addr_sel is the owner's one-hot in OWN, so masking with it excludes the owner.
  assign w_req_others  = i_hreq & ~r_addr_sel;
  assign w_cand_all    = f_pick(i_hreq, r_last);
  assign w_cand_others = f_pick(w_req_others, r_last);

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= IW'(MASTER_NUM - 1);
      r_cnt      <= '0;
      r_addr_sel <= '0;
      r_data_sel <= '0;
      r_hmaster  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_sel <= w_addr_sel_nxt;
      r_data_sel <= w_data_sel_nxt;
      r_hmaster  <= w_hmaster_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_data_sel_nxt = r_data_sel;
    if (i_hready) begin
      w_data_sel_nxt = (r_state == S_OWN && w_own_active) ? r_addr_sel : '0;
      case (r_state)
        S_IDLE: begin
          if (|i_hreq) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_cand_all;
            w_last_nxt  = w_cand_all;
            w_cnt_nxt   = '0;
          end
        end
        S_OWN: begin
          if (w_own_lock) begin
            if (w_own_active && r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
          end else if (!w_own_req) begin
            w_cnt_nxt = '0;
            if (|i_hreq) begin
              w_owner_nxt = w_cand_all;
              w_last_nxt  = w_cand_all;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (r_cnt == CNT_MAX && w_own_active && |w_req_others) begin
            w_owner_nxt = w_cand_others;
            w_last_nxt  = w_cand_others;
            w_cnt_nxt   = '0;
          end else if (w_own_active && r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr_sel_nxt = '0;
    w_hmaster_nxt  = '0;
    w_busy_nxt     = 1'b0;
    if (w_state_nxt == S_OWN) begin
      w_addr_sel_nxt[w_owner_nxt] = 1'b1;
      w_hmaster_nxt               = w_owner_nxt;
      w_busy_nxt                  = 1'b1;
    end
  end

  assign o_addr_sel = r_addr_sel;
  assign o_data_sel = r_data_sel;
  assign o_hmaster  = r_hmaster;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb/tb_ahb_slave_arbiter.sv - directed bench with an ownership model for ahb_slave_arbiter
module tb_ahb_slave_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            hreset;
  logic [N-1:0]    hreq;
  logic [N-1:0]    hlock;
  logic [N-1:0][1:0] htrans;
  logic            hready;
  logic [N-1:0]    addr_sel;
  logic [N-1:0]    data_sel;
  logic [1:0]      hmaster;
  logic            busy;

  int checks = 0;
  int errors = 0;

  ahb_slave_arbiter #(.MASTER_NUM(N), .MAX_BURST(MB)) dut (
    .i_hclk     (clk),
    .i_hreset   (hreset),
    .i_hreq     (hreq),
    .i_hlock    (hlock),
    .i_htrans   (htrans),
    .i_hready   (hready),
    .o_addr_sel (addr_sel),
    .o_data_sel (data_sel),
    .o_hmaster  (hmaster),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 = nobody), last winner, accepted beats, data-phase one-hot.
  int         m_owner = -1;
  int         m_last  = N - 1;
  int         m_beats = 0;
  logic [N-1:0] m_dsel = '0;
  bit         armed   = 1'b0;

  function automatic int pick(input logic [N-1:0] req, input int from);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (from + i) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (hreset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_beats = 0;
      m_dsel  = '0;
      armed   = 1'b1;
    end else if (hready) begin
      logic         act;
      logic [N-1:0] others;
      int           c;
      act    = (m_owner >= 0) ? htrans[m_owner][1] : 1'b0;
      m_dsel = act ? N'(1 << m_owner) : '0;
      if (m_owner < 0) begin
        c = pick(hreq, m_last);
        if (c >= 0) begin m_owner = c; m_last = c; m_beats = 0; end
      end else begin
        others = hreq & ~N'(1 << m_owner);
        if (hlock[m_owner]) begin
          if (act && m_beats < MB - 1) m_beats++;
        end else if (!hreq[m_owner]) begin
          c = pick(hreq, m_last);
          m_owner = c;
          m_beats = 0;
          if (c >= 0) m_last = c;
        end else if (m_beats == MB - 1 && act && others != 0) begin
          c = pick(others, m_last);
          m_owner = c; m_last = c; m_beats = 0;
        end else if (act && m_beats < MB - 1) begin
          m_beats++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [N-1:0] e_addr;
      e_addr = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      checks += 4;
      if (addr_sel !== e_addr) begin
        errors++;
        $display("FAIL model_addr_sel t=%0t actual=%b required=%b", $time, addr_sel, e_addr);
      end
      if (data_sel !== m_dsel) begin
        errors++;
        $display("FAIL model_data_sel t=%0t actual=%b required=%b", $time, data_sel, m_dsel);
      end
      if (hmaster !== 2'((m_owner >= 0) ? m_owner : 0)) begin
        errors++;
        $display("FAIL model_hmaster t=%0t actual=%0d required=%0d", $time, hmaster,
                 (m_owner >= 0) ? m_owner : 0);
      end
      if (busy !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL model_busy t=%0t actual=%b required=%b", $time, busy, m_owner >= 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    hreq   = '0;
    hlock  = '0;
    htrans = '0;
    hready = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_addr_sel", 32'(addr_sel), 32'h0);
    chk("reset_data_sel", 32'(data_sel), 32'h0);
    chk("reset_hmaster", 32'(hmaster), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // single requester
    hreq = 4'b0001;
    tick();
    chk("single_addr_sel", 32'(addr_sel), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    htrans[0] = 2'b10;
    tick();
    chk("single_data_sel", 32'(data_sel), 32'h1);
    hreq = '0;
    htrans = '0;
    tick();
    chk("single_release_busy", 32'(busy), 32'h0);

    // round robin, each master drops hreq after one beat
    do_reset();
    hreq   = 4'b1111;
    htrans = {4{2'b10}};
    tick();
    for (int k = 0; k <= 4; k++) begin
      int o;
      o = k % N;
      chk($sformatf("rr_grant%0d", k), 32'(addr_sel), 32'(1 << o));
      if (k < 4) begin
        tick();
        hreq[o] = 1'b0;
        tick();
        chk($sformatf("rr_no_gap%0d", k), 32'(busy), 32'h1);
        hreq[o] = 1'b1;
      end
    end

    // burst limit: master 1 released after 4th accepted beat
    do_reset();
    hreq = 4'b0010;
    tick();
    chk("burst_grant", 32'(addr_sel), 32'h2);
    hreq      = 4'b0110;
    htrans[1] = 2'b10;
    tick();
    htrans[1] = 2'b11;
    tick();
    tick();
    chk("burst_hold_beat3", 32'(addr_sel), 32'h2);
    tick();
    chk("burst_release", 32'(addr_sel), 32'h4);
    chk("burst_data_sel", 32'(data_sel), 32'h2);

    // lock holds ownership across 20 beats
    do_reset();
    hreq      = 4'b0001;
    hlock     = 4'b0001;
    htrans[0] = 2'b10;
    tick();
    hreq      = 4'b1001;
    htrans[0] = 2'b11;
    for (int b = 0; b < 20; b++) begin
      tick();
      chk($sformatf("lock_hold%0d", b), 32'(addr_sel), 32'h1);
    end
    hlock = '0;
    tick();
    chk("lock_release", 32'(addr_sel), 32'h8);

    // wait states freeze every select
    do_reset();
    hreq = 4'b0001;
    tick();
    htrans[0] = 2'b10;
    tick();
    chk("wait_pre_data_sel", 32'(data_sel), 32'h1);
    hready = 1'b0;
    hreq   = 4'b0100;
    for (int w = 0; w < 5; w++) begin
      tick();
      chk($sformatf("wait_addr%0d", w), 32'(addr_sel), 32'h1);
      chk($sformatf("wait_data%0d", w), 32'(data_sel), 32'h1);
      chk($sformatf("wait_hmaster%0d", w), 32'(hmaster), 32'h0);
    end
    hready = 1'b1;
    tick();
    chk("wait_switch_addr", 32'(addr_sel), 32'h4);
    chk("wait_switch_hmaster", 32'(hmaster), 32'h2);
    chk("wait_switch_data", 32'(data_sel), 32'h1);

    // reset in the middle of a master 2 burst
    do_reset();
    hreq      = 4'b0100;
    htrans[2] = 2'b10;
    tick();
    htrans[2] = 2'b11;
    tick();
    tick();
    hreset = 1'b1;
    tick();
    chk("midrst_addr_sel", 32'(addr_sel), 32'h0);
    chk("midrst_data_sel", 32'(data_sel), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    hreset = 1'b0;
    hreq   = 4'b1111;
    tick();
    chk("midrst_first_grant", 32'(addr_sel), 32'h1);

    // request arriving in IDLE while hready is low waits
    do_reset();
    hready = 1'b0;
    hreq   = 4'b0010;
    tick();
    tick();
    chk("idle_wait_busy", 32'(busy), 32'h0);
    hready = 1'b1;
    tick();
    chk("idle_wait_grant", 32'(addr_sel), 32'h2);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
